div_sched: RTL

Round-robin scheduler that shares one 10-bit sequential divider (`div_top`) between two requesters. It arbitrates, latches the winner's operands and pulses the divider's `start`. It then waits for completion, with a watchdog, and returns quotient and flags on a shared result bus with a per-requester valid strobe. It sits between the requester blocks and the single `div_top` instance; it does not reset the divider, because the divider has no reset input.

---
 rtl/div_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/div_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the divider scheduler: operand width,
//               default watchdog limit, FSM state encoding and the requester
//               index type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DW      = 10;   // operand / quotient width
    localparam int TIMEOUT = 63;   // max WAIT cycles before the op is aborted

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_sched_state_t;

    // Two requesters, so one bit selects between them.
    typedef logic req_idx_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter, purely combinational. When
//               both inputs request, the one that was not granted last wins.
//               The last-grant pointer itself is owned by the caller.
// Ports       : req  [1:0] in  - request per input
//               last       in  - index of the input granted most recently
//               gnt  [1:0] out - one-hot grant, or zero if no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import div_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
// Module      : div_sched
// Description : Shares one sequential divider between two requesters.
//               Arbitrates round-robin, latches the winner's operands, pulses
//               the divider start, waits for completion under a watchdog and
//               returns the result on a shared bus with a per-requester
//               one-cycle valid strobe. Zero divisors are answered directly
//               without using the divider.
// Ports       : clk, rst                 - clock, async active-high reset
//               req_valid/req_ready [1:0]- request handshake per requester
//               req_a0/b0, req_a1/b1     - operands per requester
//               rsp_valid [1:0]          - response strobe per requester
//               rsp_q, rsp_ov, rsp_dvz,
//               rsp_err                  - shared result, held until next RESP
//               div_start, div_a, div_b  - divider command side
//               div_q, div_busy, div_valid,
//               div_ov, div_dvz          - divider result side
// Revision    : 1.0 - initial release
// ============================================================================
module div_sched #(
    parameter int DW      = div_pkg::DW,
    parameter int TIMEOUT = div_pkg::TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_q,
    output logic          rsp_ov,
    output logic          rsp_dvz,
    output logic          rsp_err,
    output logic          div_start,
    output logic [DW-1:0] div_a,
    output logic [DW-1:0] div_b,
    input  logic [DW-1:0] div_q,
    input  logic          div_busy,
    input  logic          div_valid,
    input  logic          div_ov,
    input  logic          div_dvz
);

    import div_pkg::*;

    // r_cnt holds the number of WAIT cycles already completed, so it only
    // needs to reach TIMEOUT-1.
    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    div_sched_state_t   r_state;
    div_sched_state_t   w_state_nxt;
    req_idx_t           r_owner;
    req_idx_t           r_last;
    logic [c_CNT_W-1:0] r_cnt;

    logic [1:0]         w_arb_gnt;
    logic               w_arb_en;
    logic               w_grant;
    req_idx_t           w_win;
    logic [DW-1:0]      w_a;
    logic [DW-1:0]      w_b;
    logic               w_done;
    logic               w_tmo;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (r_last),
        .gnt  (w_arb_gnt)
    );

    // Grants only from IDLE with the divider free. Gating with rst keeps
    // req_ready low for the whole reset interval, not just after the edge.
    assign w_arb_en  = (r_state == IDLE) && !div_busy && !rst;
    assign req_ready = w_arb_en ? w_arb_gnt : 2'b00;
    assign w_grant   = |req_ready;
    assign w_win     = req_ready[1];
    assign w_a       = w_win ? req_a1 : req_a0;
    assign w_b       = w_win ? req_b1 : req_b0;

    assign div_start = (r_state == ISSUE);
    assign rsp_valid = (r_state == RESP) ? {r_owner, ~r_owner} : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = (w_b == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // div_valid seen in the first WAIT cycle belongs to the
                // previous operation, so it only counts once r_cnt != 0.
                if ((r_cnt != '0) && div_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;     // requester 0 wins the first tie
            r_cnt   <= '0;
            div_a   <= '0;
            div_b   <= '0;
            rsp_q   <= '0;
            rsp_ov  <= 1'b0;
            rsp_dvz <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_win;
                        div_a   <= w_a;
                        div_b   <= w_b;
                        if (w_b == '0) begin
                            rsp_q   <= '0;
                            rsp_ov  <= 1'b0;
                            rsp_dvz <= 1'b1;
                            rsp_err <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        rsp_q   <= div_q;
                        rsp_ov  <= div_ov;
                        rsp_dvz <= div_dvz;
                        rsp_err <= 1'b0;
                    end else if (w_tmo) begin
                        rsp_q   <= '0;
                        rsp_ov  <= 1'b0;
                        rsp_dvz <= 1'b0;
                        rsp_err <= 1'b1;
                    end
                end
                RESP: begin
                    r_last <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
